// File: rtl/systolic_defs_pkg.sv
// Shared definitions for the weight-stationary systolic array: data widths,
// PE control encodings and the input feeder state encoding.
package systolic_defs;

  localparam int DEFAULT_WORD_WIDTH = 8;
  localparam int PSUM_MULT          = 4;
  localparam int DEFAULT_PSUM_WIDTH = PSUM_MULT * DEFAULT_WORD_WIDTH;

  localparam logic [1:0] CTRL_IDLE    = 2'b00;
  localparam logic [1:0] CTRL_LOAD    = 2'b01;
  localparam logic [1:0] CTRL_COMPUTE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DRAIN   = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth register delay line used to skew one activation lane.
// DEPTH=0 degenerates to a plain wire.
module skew_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk | reset_n;
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    // NOTE: every stage is reset, not just the last one, so a reset mid-tile
    // cannot leak stale activations onto the array edge a few cycles later.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/systolic_input_feeder.sv
// Input feeder for the systolic array: loads weights, streams skewed activations,
// drains the array and pulses done. FEEDER_STALL_CNT_EN adds a stall_count port.
module systolic_input_feeder
  import systolic_defs::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 start,
  input  logic [CNT_WIDTH-1:0]                 vec_count,
  input  logic                                 w_valid,
  output logic                                 w_ready,
  input  logic [COLS*WORD_WIDTH-1:0]           w_data,
  input  logic                                 x_valid,
  output logic                                 x_ready,
  input  logic [ROWS*WORD_WIDTH-1:0]           x_data,
  output logic [1:0]                           control_out,
  output logic [COLS*PSUM_MULT*WORD_WIDTH-1:0] d_top,
  output logic [ROWS*WORD_WIDTH-1:0]           a_left,
  output logic [ROWS-1:0]                      a_valid,
  output logic                                 busy,
`ifdef FEEDER_STALL_CNT_EN
  output logic [31:0]                          stall_count,
`endif
  output logic                                 done
);

  localparam int PSUM_WIDTH = PSUM_MULT * WORD_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_BEAT  = CNT_WIDTH'(ROWS - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_DRAIN = CNT_WIDTH'(ROWS + COLS - 2);

  feeder_state_e state_q, state_d;
  logic [CNT_WIDTH-1:0] vec_total_q, vec_total_d;
  // One counter serves as beat index, vector index and drain index in turn.
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic start_ok, w_beat, x_beat, tile_end;
  logic [1:0] ctrl_d;
  logic [COLS*PSUM_WIDTH-1:0] d_top_d;
  logic [ROWS*WORD_WIDTH-1:0] a_stage_q;
  logic [ROWS-1:0] v_stage_q;

  // The done cycle already shows IDLE, but a start seen there still belongs
  // to the finished tile and is dropped.
  assign start_ok = (state_q == ST_IDLE) && start && !done;
  assign w_beat   = (state_q == ST_LOAD) && w_valid;
  assign x_beat   = (state_q == ST_COMPUTE) && x_valid;

  // NOTE: state and counters use non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      vec_total_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vec_total_q <= vec_total_d;
    end
  end

  // NOTE: all outputs of this block get a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vec_total_d = vec_total_q;
    tile_end    = 1'b0;
    ctrl_d      = CTRL_IDLE;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d     = ST_LOAD;
          cnt_d       = '0;
          vec_total_d = vec_count;
        end
      end
      ST_LOAD: begin
        if (w_beat) begin
          ctrl_d = CTRL_LOAD;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = (vec_total_q == '0) ? ST_DRAIN : ST_COMPUTE;
          end
        end
      end
      ST_COMPUTE: begin
        ctrl_d = CTRL_COMPUTE;
        if (x_beat) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == vec_total_q - 1'b1) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        ctrl_d = CTRL_COMPUTE;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_DRAIN) begin
          cnt_d    = '0;
          state_d  = ST_IDLE;
          tile_end = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    d_top_d = '0;
    if (w_beat) begin
      for (int c = 0; c < COLS; c++) begin
        d_top_d[c*PSUM_WIDTH +: PSUM_WIDTH] = PSUM_WIDTH'(w_data[c*WORD_WIDTH +: WORD_WIDTH]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      control_out <= CTRL_IDLE;
      d_top       <= '0;
      w_ready     <= 1'b0;
      x_ready     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      a_stage_q   <= '0;
      v_stage_q   <= '0;
    end else begin
      control_out <= ctrl_d;
      d_top       <= d_top_d;
      w_ready     <= (state_d == ST_LOAD);
      x_ready     <= (state_d == ST_COMPUTE);
      busy        <= (state_d != ST_IDLE);
      done        <= tile_end;
      a_stage_q   <= x_beat ? x_data : '0;
      v_stage_q   <= {ROWS{x_beat}};
    end
  end

  // Row r sits r extra registers behind row 0 to form the diagonal wavefront.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [WORD_WIDTH:0] line_q;

    skew_delay_line #(
      .WIDTH(WORD_WIDTH + 1),
      .DEPTH(r)
    ) u_skew (
      .clk    (clk),
      .reset_n(reset_n),
      .d      ({v_stage_q[r], a_stage_q[r*WORD_WIDTH +: WORD_WIDTH]}),
      .q      (line_q)
    );

    assign a_left[r*WORD_WIDTH +: WORD_WIDTH] = line_q[WORD_WIDTH-1:0];
    assign a_valid[r] = line_q[WORD_WIDTH];
  end

`ifdef FEEDER_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (start_ok) begin
      stall_count <= '0;
    end else if ((state_q == ST_LOAD && !w_valid) || (state_q == ST_COMPUTE && !x_valid)) begin
      stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Directed self-checking bench for systolic_input_feeder (ROWS=COLS=4, 8-bit words).
module tb_systolic_input_feeder;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  vec_count = '0;
  logic         w_valid = 1'b0;
  logic         w_ready;
  logic [31:0]  w_data = '0;
  logic         x_valid = 1'b0;
  logic         x_ready;
  logic [31:0]  x_data = '0;
  logic [1:0]   control_out;
  logic [127:0] d_top;
  logic [31:0]  a_left;
  logic [3:0]   a_valid;
  logic         busy;
  logic         done;
`ifdef FEEDER_STALL_CNT_EN
  logic [31:0]  stall_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  systolic_input_feeder #(
    .WORD_WIDTH(8),
    .ROWS      (4),
    .COLS      (4),
    .CNT_WIDTH (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .vec_count  (vec_count),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_data     (w_data),
    .x_valid    (x_valid),
    .x_ready    (x_ready),
    .x_data     (x_data),
    .control_out(control_out),
    .d_top      (d_top),
    .a_left     (a_left),
    .a_valid    (a_valid),
    .busy       (busy),
`ifdef FEEDER_STALL_CNT_EN
    .stall_count(stall_count),
`endif
    .done       (done)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] dtop_of(input logic [31:0] row);
    logic [127:0] v = '0;
    for (int c = 0; c < 4; c++) v[c*32 +: 32] = {24'h0, row[c*8 +: 8]};
    return v;
  endfunction

  function automatic logic [31:0] wrow(input int k);
    logic [7:0] base = 8'(16 * (k + 1));
    return {base + 8'd3, base + 8'd2, base + 8'd1, base};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    check("rst_ctrl", control_out, 2'b00);
    check("rst_dtop", d_top, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wready", w_ready, 0);
    check("rst_xready", x_ready, 0);
    check("rst_aleft", a_left, 0);
    check("rst_avalid", a_valid, 0);
    tick();
    reset_n = 1'b1;

    // Reset in the middle of LOAD
    start = 1'b1; vec_count = 16'd2;
    tick();
    start = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_wready", w_ready, 1);
    w_valid = 1'b1; w_data = 32'h13121110;
    tick();
    check("t1_ctrl_b0", control_out, 2'b01);
    check("t1_dtop_b0", d_top, 128'h00000013_00000012_00000011_00000010);
    w_data = 32'h23222120;
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("t1_arst_ctrl", control_out, 2'b00);
    check("t1_arst_dtop", d_top, 0);
    check("t1_arst_busy", busy, 0);
    check("t1_arst_wready", w_ready, 0);
    check("t1_arst_done", done, 0);
    w_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_nodone", done, 0);
    end
    reset_n = 1'b1;

    // Basic tile: 4 weight rows, two vectors, no stalls
    start = 1'b1; vec_count = 16'd2;
    tick();
    start = 1'b0;
    check("t2_busy", busy, 1);
    check("t2_ctrl_first", control_out, 2'b00);
    for (int k = 0; k < 4; k++) begin
      w_valid = 1'b1; w_data = wrow(k);
      tick();
      check("t2_ctrl_load", control_out, 2'b01);
      check("t2_dtop", d_top, dtop_of(wrow(k)));
    end
    w_valid = 1'b0;
    check("t2_wready_off", w_ready, 0);
    check("t2_xready_on", x_ready, 1);
    x_valid = 1'b1; x_data = 32'h02020202; start = 1'b1;
    tick();
    check("t2_ctrl_comp", control_out, 2'b10);
    check("t2_dtop_zero", d_top, 0);
    check("t2_aleft_c0", a_left, 32'h00000002);
    check("t2_avalid_c0", a_valid, 4'b0001);
    x_data = 32'h03030303;
    tick();
    x_valid = 1'b0; start = 1'b0;
    check("t2_aleft_c1", a_left, 32'h00000203);
    check("t2_avalid_c1", a_valid, 4'b0011);
    check("t2_xready_off", x_ready, 0);
    check("t2_busy_comp", busy, 1);
    tick();
    check("t2_aleft_c2", a_left, 32'h00020300);
    check("t2_avalid_c2", a_valid, 4'b0110);
    check("t2_ctrl_drain", control_out, 2'b10);
    tick();
    check("t2_aleft_c3", a_left, 32'h02030000);
    check("t2_avalid_c3", a_valid, 4'b1100);
    tick();
    check("t2_aleft_c4", a_left, 32'h03000000);
    check("t2_avalid_c4", a_valid, 4'b1000);
    tick();
    check("t2_aleft_c5", a_left, 0);
    check("t2_avalid_c5", a_valid, 4'b0000);
    tick();
    tick();
    check("t2_done_early", done, 0);
    check("t2_busy_drain", busy, 1);
    start = 1'b1;
    tick();
    check("t2_done", done, 1);
    check("t2_busy_off", busy, 0);
    check("t2_ctrl_done", control_out, 2'b10);
    tick();
    check("t2_done_pulse", done, 0);
    check("t2_start_ignored_busy", busy, 0);
    check("t2_start_ignored_wready", w_ready, 0);
    check("t2_ctrl_idle", control_out, 2'b00);
    vec_count = 16'd0;
    tick();
    start = 1'b0;
    check("t3_restart_busy", busy, 1);
    check("t3_restart_wready", w_ready, 1);

    // Backpressure on weights, vec_count = 0
    begin
      int loads = 0;
      for (int i = 0; i < 7; i++) begin
        w_valid = (i % 2 == 0);
        w_data  = w_valid ? (32'h80818283 + 32'(i)) : 32'hFFFFFFFF;
        tick();
        check("t3_ctrl", control_out, (i % 2 == 0) ? 2'b01 : 2'b00);
        check("t3_dtop", d_top, (i % 2 == 0) ? dtop_of(32'h80818283 + 32'(i)) : 128'h0);
        if (control_out == 2'b01) loads++;
      end
      check("t3_loads", loads, 4);
    end
    w_valid = 1'b0;
    check("t3_xready_off", x_ready, 0);
`ifdef FEEDER_STALL_CNT_EN
    check("t3_stall", stall_count, 3);
`endif
    x_valid = 1'b1; x_data = 32'h55555555;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("t3_drain_xready", x_ready, 0);
      check("t3_drain_avalid", a_valid, 4'b0000);
      check("t3_drain_ctrl", control_out, 2'b10);
      check("t3_done", done, (i == 7));
    end
    x_valid = 1'b0;
    tick();

    // Activation bubbles: two-cycle gap between the vectors
    start = 1'b1; vec_count = 16'd2;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w_valid = 1'b1; w_data = wrow(k + 4);
      tick();
      check("t4_ctrl_load", control_out, 2'b01);
    end
    w_valid = 1'b0;
    for (int j = 0; j < 7; j++) begin
      x_valid = (j == 0) || (j == 3);
      x_data  = (j == 0) ? 32'h05050505 : ((j == 3) ? 32'h06060606 : 32'hEEEEEEEE);
      tick();
      begin
        logic [3:0]  exp_v = '0;
        logic [31:0] exp_a = '0;
        for (int r = 0; r < 4; r++) begin
          exp_v[r] = (j == r) || (j == r + 3);
          exp_a[r*8 +: 8] = (j == r) ? 8'h05 : ((j == r + 3) ? 8'h06 : 8'h00);
        end
        check("t4_avalid", a_valid, exp_v);
        check("t4_aleft", a_left, exp_a);
        check("t4_ctrl", control_out, 2'b10);
      end
`ifdef FEEDER_STALL_CNT_EN
      if (j == 3) check("t4_stall", stall_count, 2);
`endif
    end
    x_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
